// File: rtl/obi_dma_pkg.sv
// Shared types and constants for the OBI block-copy initiator.
package obi_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      FINISH
   } state_e;

   localparam logic [3:0]  OBI_BE_FULL = 4'hF;
   localparam int unsigned WORD_BYTES  = 4;

endpackage

// File: rtl/obi_dma_copy.sv
// OBI initiator copying a block of 32-bit words, one transaction outstanding at a time.
// Optional SRAM window check on start: define OBI_DMA_BOUNDS_CHECK_EN.
module obi_dma_copy
   import obi_dma_pkg::*;
#(
   parameter int unsigned LEN_W          = 14,
   parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             obi_req_o,
   input  logic             obi_gnt_i,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [3:0]       obi_be_o,
   output logic [31:0]      obi_wdata_o,
   input  logic             obi_rvalid_i,
   input  logic [31:0]      obi_rdata_i
);

   localparam logic [31:0] ALIGN_MASK = ~(32'(WORD_BYTES) - 32'd1);
   localparam logic [31:0] WORD_STEP  = 32'(WORD_BYTES);

   state_e           state_q;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [LEN_W-1:0] rem_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             req_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic [31:0]      src_al_c;
   logic [31:0]      dst_al_c;
   logic             bounds_err_c;

   assign src_al_c = src_addr_i & ALIGN_MASK;
   assign dst_al_c = dst_addr_i & ALIGN_MASK;

`ifdef OBI_DMA_BOUNDS_CHECK_EN
   // 33-bit end addresses so a block wrapping past 2^32 is rejected.
   logic [32:0] len_bytes_c;
   logic [32:0] src_end_c;
   logic [32:0] dst_end_c;

   assign len_bytes_c  = 33'(len_i) * 33'(WORD_BYTES);
   assign src_end_c    = {1'b0, src_al_c} + len_bytes_c;
   assign dst_end_c    = {1'b0, dst_al_c} + len_bytes_c;
   assign bounds_err_c = (len_i != '0) &&
                         ((src_al_c < SRAM_BASE_ADDR) || (src_end_c > {1'b0, SRAM_END_ADDR}) ||
                          (dst_al_c < SRAM_BASE_ADDR) || (dst_end_c > {1'b0, SRAM_END_ADDR}));
`else
   // Window parameters only take effect when the check is compiled in.
   assign bounds_err_c = 1'b0 & (SRAM_END_ADDR > SRAM_BASE_ADDR);
`endif

   // Copy sequencer: read, await response, write, await response, repeat.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q <= src_al_c;
                  dst_q <= dst_al_c;
                  rem_q <= len_i;
                  err_q <= bounds_err_c;
                  if ((len_i == '0) || bounds_err_c) begin
                     state_q <= FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RD_REQ;
                     busy_q  <= 1'b1;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= src_al_c;
                  end
               end
            end
            RD_REQ: begin
               if (obi_gnt_i) begin
                  state_q <= RD_WAIT;
                  req_q   <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (obi_rvalid_i) begin
                  state_q <= WR_REQ;
                  wdata_q <= obi_rdata_i;
                  req_q   <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= dst_q;
               end
            end
            WR_REQ: begin
               if (obi_gnt_i) begin
                  state_q <= WR_WAIT;
                  req_q   <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (obi_rvalid_i) begin
                  src_q <= src_q + WORD_STEP;
                  dst_q <= dst_q + WORD_STEP;
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= FINISH;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RD_REQ;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     addr_q  <= src_q + WORD_STEP;
                  end
               end
            end
            FINISH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign obi_req_o   = req_q;
   assign obi_addr_o  = addr_q;
   assign obi_we_o    = we_q;
   assign obi_be_o    = OBI_BE_FULL;
   assign obi_wdata_o = wdata_q;

endmodule

// File: tb/tb_obi_dma_copy.sv
// Scoreboard bench for obi_dma_copy against a 48 kB OBI memory responder.
`timescale 1ns/1ps
module tb_obi_dma_copy;

   localparam int unsigned LEN_W     = 14;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int unsigned MEM_WORDS = 12288;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [31:0]      src;
   logic [31:0]      dst;
   logic [LEN_W-1:0] len;
   logic             busy, done, err;
   logic             req, gnt, we;
   logic [31:0]      addr, wdata;
   logic [3:0]       be;
   logic             rvalid = 1'b0;
   logic [31:0]      rdata  = '0;

   obi_dma_copy #(.LEN_W(LEN_W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
      .busy_o(busy), .done_o(done), .err_o(err),
      .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(addr), .obi_we_o(we),
      .obi_be_o(be), .obi_wdata_o(wdata), .obi_rvalid_i(rvalid), .obi_rdata_i(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      chk_cnt++;
      $display("FAIL %s: event did not match expectation", name);
   endtask

   function automatic logic [31:0] init_word(input int unsigned i);
      if (i < 4) return 32'(i + 1);
      return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
   endfunction

   function automatic int unsigned widx(input logic [31:0] a);
      return 32'((a - BASE) >> 2);
   endfunction

   // Responder: gnt after gnt_wait request cycles, rvalid on the cycle after the grant.
   logic [31:0] mem [MEM_WORDS];
   logic        mem_ready = 1'b0;
   int unsigned gnt_wait  = 0;
   int unsigned wait_cnt  = 0;
   logic        inj_rvalid = 1'b0;
   int          cyc = 0;

   assign gnt = req && (wait_cnt >= gnt_wait);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_word(32'(i));
         mem_ready <= 1'b1;
      end
      wait_cnt <= (req && !gnt) ? wait_cnt + 1 : 0;
      rvalid   <= 1'b0;
      if (req && gnt) begin
         rvalid <= 1'b1;
         if (widx(addr) < MEM_WORDS) begin
            if (we) mem[widx(addr)] <= wdata;
            else    rdata <= mem[widx(addr)];
         end else if (!we) begin
            rdata <= 32'hDEAD_BEEF;
         end
      end else if (inj_rvalid) begin
         rvalid <= 1'b1;
         rdata  <= 32'hBAD0_0000;
      end
   end

   // Reference model: sequential word copy over a private memory image.
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic [31:0] model [MEM_WORDS];
   wr_t         wr_q[$];
   logic        done_exp_q[$];

   task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n);
      logic [31:0] sa, da;
      sa = s & ~32'h3;
      da = d & ~32'h3;
      for (int unsigned i = 0; i < n; i++) begin
         wr_t w;
         w.a = da + 32'(4 * i);
         w.d = model[widx(sa + 32'(4 * i))];
         model[widx(w.a)] = w.d;
         wr_q.push_back(w);
      end
   endtask

   // Monitor: writes, completion pulses and request stability.
   int          done_cnt = 0, done_cyc = 0, wr_seen = 0, req_cycles = 0, busy_cycles = 0;
   logic        prev_pend = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (req) req_cycles++;
         if (busy) busy_cycles++;
         if (req && prev_pend) begin
            check("stable_addr", addr, prev_addr);
            check("stable_we", 32'(we), 32'(prev_we));
            if (we) check("stable_wdata", wdata, prev_wdata);
         end
         prev_pend  = req && !gnt;
         prev_addr  = addr;
         prev_we    = we;
         prev_wdata = wdata;
         if (req && gnt && we) begin
            wr_seen++;
            check("be_full", 32'(be), 32'hF);
            if (wr_q.size() == 0) fail_now("unexpected_write");
            else begin
               wr_t w;
               w = wr_q.pop_front();
               check("wr_addr", addr, w.a);
               check("wr_data", wdata, w.d);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 32'(busy), 32'h0);
            if (done_exp_q.size() == 0) fail_now("unexpected_done");
            else check("err_at_done", 32'(err), 32'(done_exp_q.pop_front()));
         end
      end else begin
         prev_pend = 1'b0;
      end
   end

   int start_cyc = 0;

   task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
      @(posedge clk); #1;
      src = s; dst = d; len = l; start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      for (int i = 0; i < 2000 && done_cnt < target; i++) begin
         @(negedge clk); #1;
      end
      if (done_cnt < target) fail_now(name);
   endtask

   task automatic copy_job(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                           input string name);
      int tgt;
      tgt = done_cnt + 1;
      model_copy(s, d, n);
      done_exp_q.push_back(1'b0);
      do_start(s, d, LEN_W'(n));
      wait_done(tgt, name);
   endtask

   initial begin
      int base_req, base_busy, tgt, base_done, mism;
      logic [31:0] s, d;
      int unsigned n;

      for (int i = 0; i < MEM_WORDS; i++) model[i] = init_word(32'(i));
      rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(req), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_be", 32'(be), 32'hF);
      check("rst_addr", addr, 32'h0);
      check("rst_we_wdata", {31'h0, we} | wdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // T1: 4-word copy with zero-wait responder
      base_busy = busy_cycles;
      copy_job(32'h8000_0000, 32'h8000_0100, 4, "t1_done_timeout");
      check("t1_done_latency", 32'(done_cyc - start_cyc), 32'd17);
      check("t1_busy_cycles", 32'(busy_cycles - base_busy), 32'd16);
      for (int i = 0; i < 4; i++) check("t1_dst_word", mem[64 + i], 32'(i + 1));

      // T2: zero-length transfer
      base_req = req_cycles;
      tgt = done_cnt + 1;
      done_exp_q.push_back(1'b0);
      do_start(32'h8000_0040, 32'h8000_0200, '0);
      wait_done(tgt, "t2_done_timeout");
      check("t2_done_latency", 32'(done_cyc - start_cyc), 32'd1);
      repeat (3) @(negedge clk);
      check("t2_no_req", 32'(req_cycles - base_req), 32'h0);

      // T3: grant held off three cycles per request
      gnt_wait = 3;
      copy_job(32'h8000_1000, 32'h8000_2002, 5, "t3_done_timeout");
      gnt_wait = 0;

      // T4: reset during the second write response of an 8-word copy
      base_done = done_cnt;
      model_copy(32'h8000_3000, 32'h8000_4000, 2);
      tgt = wr_seen + 2;
      do_start(32'h8000_3000, 32'h8000_4000, LEN_W'(8));
      for (int i = 0; i < 200 && wr_seen < tgt; i++) begin
         @(negedge clk); #1;
      end
      if (wr_seen < tgt) fail_now("t4_write_timeout");
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("t4_req_after_rst", 32'(req), 32'h0);
      check("t4_busy_after_rst", 32'(busy), 32'h0);
      base_req = req_cycles;
      inj_rvalid = 1'b1;
      @(posedge clk); #1;
      inj_rvalid = 1'b0;
      repeat (6) @(negedge clk);
      check("t4_late_rvalid_no_req", 32'(req_cycles - base_req), 32'h0);
      check("t4_no_done", 32'(done_cnt - base_done), 32'h0);
      copy_job(32'h8000_5000, 32'h8000_5100, 3, "t4_restart_timeout");

      // T5: start pulses while busy are ignored
      tgt = done_cnt + 1;
      model_copy(32'h8000_6000, 32'h8000_7000, 6);
      done_exp_q.push_back(1'b0);
      do_start(32'h8000_6000, 32'h8000_7000, LEN_W'(6));
      repeat (3) @(posedge clk);
      do_start(32'h8000_0000, 32'h8000_8000, LEN_W'(3));
      wait_done(tgt, "t5_done_timeout");
      repeat (20) @(negedge clk);
      check("t5_no_extra_done", 32'(done_cnt), 32'(tgt));

`ifdef OBI_DMA_BOUNDS_CHECK_EN
      // T6: out-of-window source aborts with err and no request
      base_req = req_cycles;
      tgt = done_cnt + 1;
      done_exp_q.push_back(1'b1);
      do_start(32'h8000_BFFC, 32'h8000_0400, LEN_W'(2));
      wait_done(tgt, "t6_done_timeout");
      repeat (3) @(negedge clk);
      check("t6_no_req", 32'(req_cycles - base_req), 32'h0);
      check("t6_err_sticky", 32'(err), 32'h1);
      tgt = done_cnt + 1;
      done_exp_q.push_back(1'b1);
      do_start(32'h8000_0400, 32'h7FFF_FFFC, LEN_W'(1));
      wait_done(tgt, "t6_dst_done_timeout");
      tgt = done_cnt + 1;
      model_copy(32'h8000_BFF8, 32'h8000_0800, 2);
      done_exp_q.push_back(1'b0);
      do_start(32'h8000_BFF8, 32'h8000_0800, LEN_W'(2));
      @(negedge clk);
      check("t6_err_cleared", 32'(err), 32'h0);
      wait_done(tgt, "t6_valid_done_timeout");
`endif

      // Randomized copies with varying grant latency
      for (int k = 0; k < 8; k++) begin
         n = $urandom_range(16, 1);
         s = BASE + 32'(4 * $urandom_range(MEM_WORDS - n, 0)) + 32'($urandom_range(3, 0));
         d = BASE + 32'(4 * $urandom_range(MEM_WORDS - n, 0));
         gnt_wait = $urandom_range(2, 0);
         copy_job(s, d, n, "rand_done_timeout");
      end
      gnt_wait = 0;

      repeat (5) @(negedge clk);
      check("wr_queue_empty", 32'(wr_q.size()), 32'h0);
      check("done_queue_empty", 32'(done_exp_q.size()), 32'h0);
      mism = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== model[i]) mism++;
      check("mem_image", 32'(mism), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
